cla_pipe_adder: RTL and testbench



---
 rtl/cla_pipe_adder.sv | 165 ++++++++++++++++
 tb/tb_cla_pipe_adder.sv | 174 +++++++++++++++++
 2 files changed

// File: rtl/cla_pipe_adder.sv
// Pipelined carry-lookahead adder: one SEG-bit segment of 4-bit CLA groups per stage, valid/ready stream.
// Optional carry-disregard approximation on the low APPROX_BITS bits when CLA_APPROX_EN is defined.
module cla_pipe_adder #(
  parameter int WIDTH       = 32,
  parameter int STAGES      = 4,
  parameter int APPROX_BITS = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  input  logic             approx,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] s,
  output logic             cout
);

  localparam int SEG = WIDTH / STAGES;
  localparam int NG  = SEG / 4;
  localparam logic [WIDTH-1:0] AMASK = (WIDTH'(1) << APPROX_BITS) - WIDTH'(1);

  // Sum-of-products lookahead at both group and bit level, so no carry ripples across groups.
  function automatic logic [SEG:0] seg_add(input logic [SEG-1:0] x, input logic [SEG-1:0] y,
                                           input logic ci);
    logic [SEG-1:0] p, g, sum;
    logic [NG-1:0]  gp, gg;
    logic [NG:0]    gc;
    logic [3:0]     bc;
    logic           prod;
    p   = x ^ y;
    g   = x & y;
    sum = {SEG{1'b0}};
    bc  = 4'b0000;
    for (int j = 0; j < NG; j++) begin
      gp[j] = &p[4*j +: 4];
      gg[j] = g[4*j+3] | (p[4*j+3] & g[4*j+2]) | (p[4*j+3] & p[4*j+2] & g[4*j+1])
            | (p[4*j+3] & p[4*j+2] & p[4*j+1] & g[4*j]);
    end
    gc[0] = ci;
    for (int j = 1; j <= NG; j++) begin
      gc[j] = 1'b0;
      prod  = 1'b1;
      for (int i = j - 1; i >= 0; i--) begin
        gc[j] = gc[j] | (gg[i] & prod);
        prod  = prod & gp[i];
      end
      gc[j] = gc[j] | (ci & prod);
    end
    for (int j = 0; j < NG; j++) begin
      for (int m = 0; m < 4; m++) begin
        bc[m] = 1'b0;
        prod  = 1'b1;
        for (int i = m - 1; i >= 0; i--) begin
          bc[m] = bc[m] | (g[4*j+i] & prod);
          prod  = prod & p[4*j+i];
        end
        bc[m] = bc[m] | (gc[j] & prod);
        sum[4*j+m] = p[4*j+m] ^ bc[m];
      end
    end
    return {gc[NG], sum};
  endfunction

  logic              advance;
  logic [STAGES-1:0] v_r, c_r;
  logic [WIDTH-1:0]  sum_r [STAGES];
  logic [WIDTH-1:0]  a_r   [STAGES];
  logic [WIDTH-1:0]  b_r   [STAGES];

  // Stage inputs: stage 0 sees the ports, stage k sees slot k-1.
  logic [WIDTH-1:0]  pa [STAGES];
  logic [WIDTH-1:0]  pb [STAGES];
  logic [WIDTH-1:0]  ps [STAGES];
  logic [STAGES-1:0] pc, pv, px;
  logic [WIDTH-1:0]  n_sum [STAGES];
  logic [STAGES-1:0] n_c;
  logic [WIDTH-1:0]  msk;
  logic [SEG-1:0]    op_x, op_y;
  logic              op_c;
  logic [SEG:0]      res;

  assign advance   = ~v_r[STAGES-1] | out_ready;
  assign in_ready  = advance;
  assign out_valid = v_r[STAGES-1];
  assign s         = sum_r[STAGES-1];
  assign cout      = c_r[STAGES-1];

  assign pa[0] = a;
  assign pb[0] = b;
  assign ps[0] = {WIDTH{1'b0}};
  assign pc[0] = cin;
  assign pv[0] = in_valid;

  for (genvar k = 1; k < STAGES; k++) begin : g_link
    assign pa[k] = a_r[k-1];
    assign pb[k] = b_r[k-1];
    assign ps[k] = sum_r[k-1];
    assign pc[k] = c_r[k-1];
    assign pv[k] = v_r[k-1];
  end

`ifdef CLA_APPROX_EN
  logic x_r [STAGES];
  assign px[0] = approx;
  for (genvar k = 1; k < STAGES; k++) begin : g_xlink
    assign px[k] = x_r[k-1];
  end
`else
  logic unused_approx;
  assign unused_approx = approx;
  assign px = {STAGES{1'b0}};
`endif

  // Per-stage segment add; approx bits become a^b with b cleared, so they can neither generate nor absorb a carry.
  always_comb begin
    msk  = {WIDTH{1'b0}};
    op_x = {SEG{1'b0}};
    op_y = {SEG{1'b0}};
    op_c = 1'b0;
    res  = {(SEG+1){1'b0}};
    n_c  = {STAGES{1'b0}};
    for (int k = 0; k < STAGES; k++) begin
      msk  = px[k] ? AMASK : {WIDTH{1'b0}};
      op_x = pa[k][k*SEG +: SEG] ^ (pb[k][k*SEG +: SEG] & msk[k*SEG +: SEG]);
      op_y = pb[k][k*SEG +: SEG] & ~msk[k*SEG +: SEG];
      op_c = pc[k] & ~(px[k] & AMASK[k*SEG]);
      res  = seg_add(op_x, op_y, op_c);
      n_sum[k] = ps[k];
      n_sum[k][k*SEG +: SEG] = res[SEG-1:0];
      n_c[k] = res[SEG];
    end
  end

  // Slot registers: the whole pipe advances together or holds together.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      v_r <= {STAGES{1'b0}};
      c_r <= {STAGES{1'b0}};
      for (int k = 0; k < STAGES; k++) begin
        sum_r[k] <= {WIDTH{1'b0}};
        a_r[k]   <= {WIDTH{1'b0}};
        b_r[k]   <= {WIDTH{1'b0}};
`ifdef CLA_APPROX_EN
        x_r[k]   <= 1'b0;
`endif
      end
    end else if (advance) begin
      v_r <= pv;
      c_r <= n_c;
      for (int k = 0; k < STAGES; k++) begin
        sum_r[k] <= n_sum[k];
        a_r[k]   <= pa[k];
        b_r[k]   <= pb[k];
`ifdef CLA_APPROX_EN
        x_r[k]   <= px[k];
`endif
      end
    end
  end

endmodule

// File: tb/tb_cla_pipe_adder.sv
// Scoreboard bench for cla_pipe_adder (WIDTH=32, STAGES=4): directed vectors, queue-based monitor.
module tb_cla_pipe_adder;
  logic        clk = 1'b0;
  logic        rst_n, in_valid, in_ready, cin, approx, out_valid, out_ready, cout;
  logic [31:0] a, b, s;
  logic [32:0] exp_q [$];
  logic [32:0] mon_exp;
  int          errors = 0;
  int          checks = 0;
  int          cyc = 0;

  cla_pipe_adder #(.WIDTH(32), .STAGES(4), .APPROX_BITS(8)) dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
    .a(a), .b(b), .cin(cin), .approx(approx),
    .out_valid(out_valid), .out_ready(out_ready), .s(s), .cout(cout));

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] expv);
    checks++;
    if (act !== expv) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, expv);
    end
  endtask

  task automatic send(input logic [31:0] ta, input logic [31:0] tb, input logic tc,
                      input logic tx, input logic [32:0] e);
    int n;
    n = 0;
    a = ta; b = tb; cin = tc; approx = tx; in_valid = 1'b1;
    #1;
    while (!in_ready && n < 200) begin
      @(negedge clk); #1; n++;
    end
    if (!in_ready) begin
      checks++; errors++;
      $display("FAIL accept_timeout: in_ready stuck at 0 after %0d cycles", n);
    end else begin
      exp_q.push_back(e);
    end
    @(negedge clk);
    in_valid = 1'b0;
  endtask

  task automatic wait_valid(input string name, input int want);
    int n;
    n = 0;
    while (!out_valid && n < 40) begin
      @(negedge clk); n++;
    end
    chk(name, 64'(n), 64'(want));
  endtask

  task automatic drain();
    int n;
    n = 0;
    while (exp_q.size() != 0 && n < 200) begin
      @(negedge clk); n++;
    end
    chk("drain_empty", 64'(exp_q.size()), 64'd0);
    @(negedge clk);
  endtask

  // Monitor: pop and compare on every completed output handshake
  always @(negedge clk) begin
    #2;
    if (rst_n && out_valid && out_ready) begin
      if (exp_q.size() == 0) begin
        checks++; errors++;
        $display("FAIL unexpected_output: got %h expected none", {cout, s});
      end else begin
        mon_exp = exp_q.pop_front();
        chk("result", 64'({cout, s}), 64'(mon_exp));
      end
    end
  end

  logic [31:0] bp_a [6] = '{32'h00000001, 32'h80000000, 32'h0000FFFF, 32'h12345678, 32'hFFFFFFFF, 32'h0F0F0F0F};
  logic [31:0] bp_b [6] = '{32'h00000002, 32'h80000000, 32'h00000001, 32'h11111111, 32'hFFFFFFFF, 32'hF0F0F0F0};
  logic        bp_c [6] = '{1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1};
  logic [32:0] bp_e [6] = '{33'h000000003, 33'h100000001, 33'h000010000, 33'h023456789, 33'h1FFFFFFFF, 33'h100000000};
  logic [32:0] ap_e1, ap_e2;
  logic [31:0] hold_s;
  logic        hold_c;
  int          t0;

  initial begin
`ifdef CLA_APPROX_EN
    ap_e1 = 33'h0000000FE;
    ap_e2 = 33'h0123457E0;
`else
    ap_e1 = 33'h000000101;
    ap_e2 = 33'h012345801;
`endif
    rst_n = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
    a = 32'd0; b = 32'd0; cin = 1'b0; approx = 1'b0;
    repeat (2) @(negedge clk);
    chk("reset_out_valid", 64'(out_valid), 64'd0);
    chk("reset_s", 64'(s), 64'd0);
    chk("reset_cout", 64'(cout), 64'd0);
    rst_n = 1'b1;
    #1;
    chk("reset_in_ready", 64'(in_ready), 64'd1);
    @(negedge clk);

    // All-ones plus one: carry through every segment, latency 3 edges after acceptance
    send(32'hFFFFFFFF, 32'h00000001, 1'b0, 1'b0, 33'h100000000);
    wait_valid("latency_first", 3);
    drain();

    // Exhaustive low range, back-to-back
    t0 = cyc;
    for (int i = 0; i < 20; i++)
      for (int j = 0; j < 20; j++)
        send(32'(i), 32'(j), 1'b0, 1'b0, {1'b0, 32'(i + j)});
    chk("stream_cycles", 64'(cyc - t0), 64'd400);
    drain();

    // Approximate mode versus exact on the same operands
    send(32'h000000FF, 32'h00000001, 1'b1, 1'b1, ap_e1);
    send(32'h000000FF, 32'h00000001, 1'b1, 1'b0, 33'h000000101);
    send(32'h123456F0, 32'h00000110, 1'b1, 1'b1, ap_e2);
    send(32'h123456F0, 32'h00000110, 1'b1, 1'b0, 33'h012345801);
    drain();

    // Backpressure: stall 5 cycles once output appears
    fork
      begin
        for (int i = 0; i < 6; i++) send(bp_a[i], bp_b[i], bp_c[i], 1'b0, bp_e[i]);
      end
      begin
        wait_valid("bp_first_latency", 4);
        out_ready = 1'b0;
        hold_s = s; hold_c = cout;
        repeat (5) begin
          @(negedge clk);
          chk("stall_in_ready", 64'(in_ready), 64'd0);
          chk("stall_out_valid", 64'(out_valid), 64'd1);
          chk("stall_s", 64'(s), 64'(hold_s));
          chk("stall_cout", 64'(cout), 64'(hold_c));
        end
        out_ready = 1'b1;
      end
    join
    drain();

    // Reset with three beats in flight
    out_ready = 1'b0;
    send(32'h00000011, 32'h00000022, 1'b0, 1'b0, 33'h000000033);
    send(32'h00000100, 32'h00000200, 1'b0, 1'b0, 33'h000000300);
    send(32'h00001000, 32'h00002000, 1'b0, 1'b0, 33'h000003000);
    wait_valid("rst_fill_latency", 1);
    chk("pre_reset_s", 64'(s), 64'h33);
    rst_n = 1'b0;
    exp_q.delete();
    #1;
    chk("midrst_out_valid", 64'(out_valid), 64'd0);
    chk("midrst_s", 64'(s), 64'd0);
    chk("midrst_cout", 64'(cout), 64'd0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    out_ready = 1'b1;
    @(negedge clk);
    chk("post_rst_out_valid", 64'(out_valid), 64'd0);
    send(32'd5, 32'd7, 1'b0, 1'b0, 33'd12);
    wait_valid("post_rst_latency", 3);
    drain();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
